// File: rtl/cnt_run_sched_if.sv
// Requester/counter-side signal bundle for the two-requester counter-run scheduler.
// The slave modport is the scheduler; the master modport is the surrounding logic.
interface cnt_run_sched_if;
  logic [1:0] req;
  logic [7:0] start0;
  logic [7:0] len0;
  logic [7:0] start1;
  logic [7:0] len1;
  logic [7:0] cnt_q;
  logic [1:0] gnt;
  logic       busy;
  logic       cnt_set;
  logic [7:0] cnt_set_val;
  logic       cnt_en;
  logic       cnt_oe;
  logic [7:0] result;
  logic       done;
  logic       done_id;

  modport master (
    output req, start0, len0, start1, len1, cnt_q,
    input  gnt, busy, cnt_set, cnt_set_val, cnt_en, cnt_oe, result, done, done_id
  );

  modport slave (
    input  req, start0, len0, start1, len1, cnt_q,
    output gnt, busy, cnt_set, cnt_set_val, cnt_en, cnt_oe, result, done, done_id
  );
endinterface

// File: rtl/cnt_run_sched.sv
// Round-robin scheduler sharing one loadable 8-bit counter between two requesters:
// load start, increment len times (prescaled), hold output-enable, report result.
module cnt_run_sched #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned HOLD     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  cnt_run_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, SHOW} state_t;

  localparam logic [3:0] PRE_LAST  = 4'(PRESCALE - 1);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state, state_nx;
  logic [7:0] start_q;
  logic [7:0] rem;
  logic [3:0] pre;
  logic [3:0] hcnt;
  logic       ptr;
  logic [1:0] gnt_q;
  logic       id_q;
  logic [7:0] result_q;
  logic       done_q;
  logic       done_id_q;
  logic       win;
  logic       grant;
  logic       en;
  logic       show_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    win = 1'b0;
    unique case (bus.req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ptr;
      default: win = 1'b0;
    endcase
    // done blocks arbitration for one cycle so the served requester can drop req
    grant     = (state == IDLE) && !done_q && (bus.req != 2'b00);
    en        = (state == RUN) && (pre == PRE_LAST);
    show_last = (state == SHOW) && (hcnt == HOLD_LAST);
    state_nx  = state;
    unique case (state)
      IDLE:    if (grant) state_nx = LOAD;
      LOAD:    state_nx = (rem == 8'd0) ? SHOW : RUN;
      RUN:     if (en && rem == 8'd1) state_nx = SHOW;
      SHOW:    if (show_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= '0;
      rem       <= '0;
      pre       <= '0;
      hcnt      <= '0;
      ptr       <= 1'b0;
      gnt_q     <= '0;
      id_q      <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (grant) begin
        start_q <= win ? bus.start1 : bus.start0;
        rem     <= win ? bus.len1 : bus.len0;
        gnt_q   <= win ? 2'b10 : 2'b01;
        id_q    <= win;
        ptr     <= ~win;
      end
      if (state == LOAD) begin
        pre  <= '0;
        hcnt <= '0;
      end
      if (state == RUN) begin
        pre <= en ? 4'd0 : pre + 4'd1;
        if (en) rem <= rem - 8'd1;
      end
      if (state == SHOW) hcnt <= show_last ? 4'd0 : hcnt + 4'd1;
      if (show_last) begin
        result_q  <= bus.cnt_q;
        done_q    <= 1'b1;
        done_id_q <= id_q;
        gnt_q     <= '0;
      end
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.busy        = (state != IDLE);
  assign bus.cnt_set     = (state == LOAD);
  assign bus.cnt_set_val = start_q;
  assign bus.cnt_en      = en;
  assign bus.cnt_oe      = (state == SHOW);
  assign bus.result      = result_q;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
endmodule

// File: tb/tb_cnt_run_sched.sv
// Bench for cnt_run_sched: two instances (PRESCALE=1 and 3, HOLD=2), each with a counter,
// a timeline model checked every cycle, and directed runs with literal expectations.
module tb_cnt_run_sched;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] req [2];
  logic [7:0] st0 [2];
  logic [7:0] ln0 [2];
  logic [7:0] st1 [2];
  logic [7:0] ln1 [2];
  logic [7:0] cnt [2];

  logic [1:0] o_gnt  [2];
  logic       o_busy [2];
  logic       o_set  [2];
  logic [7:0] o_setv [2];
  logic       o_en   [2];
  logic       o_oe   [2];
  logic [7:0] o_res  [2];
  logic       o_done [2];
  logic       o_did  [2];

  cnt_run_sched_if bus0();
  cnt_run_sched_if bus1();

  cnt_run_sched #(.PRESCALE(1), .HOLD(H)) u_p1 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cnt_run_sched #(.PRESCALE(3), .HOLD(H)) u_p3 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.req = req[0];  assign bus1.req = req[1];
  assign bus0.start0 = st0[0]; assign bus1.start0 = st0[1];
  assign bus0.len0 = ln0[0];   assign bus1.len0 = ln0[1];
  assign bus0.start1 = st1[0]; assign bus1.start1 = st1[1];
  assign bus0.len1 = ln1[0];   assign bus1.len1 = ln1[1];
  assign bus0.cnt_q = cnt[0];  assign bus1.cnt_q = cnt[1];

  assign o_gnt[0] = bus0.gnt;          assign o_gnt[1] = bus1.gnt;
  assign o_busy[0] = bus0.busy;        assign o_busy[1] = bus1.busy;
  assign o_set[0] = bus0.cnt_set;      assign o_set[1] = bus1.cnt_set;
  assign o_setv[0] = bus0.cnt_set_val; assign o_setv[1] = bus1.cnt_set_val;
  assign o_en[0] = bus0.cnt_en;        assign o_en[1] = bus1.cnt_en;
  assign o_oe[0] = bus0.cnt_oe;        assign o_oe[1] = bus1.cnt_oe;
  assign o_res[0] = bus0.result;       assign o_res[1] = bus1.result;
  assign o_done[0] = bus0.done;        assign o_done[1] = bus1.done;
  assign o_did[0] = bus0.done_id;      assign o_did[1] = bus1.done_id;

  // The counter being shared: set has priority over increment.
  initial begin cnt[0] = 8'h00; cnt[1] = 8'h00; end
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (o_set[i])     cnt[i] <= o_setv[i];
      else if (o_en[i]) cnt[i] <= cnt[i] + 8'd1;
    end
  end

  function automatic int pre_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: k counts cycles since the grant edge; the run is LOAD at k=0, then len*P
  // increment cycles, then H show cycles; done rises when k reaches 1+len*P+H.
  bit         m_act  [2];
  int         m_k    [2];
  logic [7:0] m_start[2];
  logic [7:0] m_len  [2];
  logic [7:0] m_res  [2];
  bit         m_id   [2];
  bit         m_ptr  [2];
  bit         m_done [2];
  bit         m_did  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 0; m_k[i] = 0; m_start[i] = 8'h00; m_len[i] = 8'h00;
        m_res[i] = 8'h00; m_id[i] = 0; m_ptr[i] = 0; m_done[i] = 0; m_did[i] = 0;
      end else begin
        bit         was_done;
        bit         w;
        logic [1:0] rq;
        was_done  = m_done[i];
        m_done[i] = 0;
        rq        = req[i];
        if (m_act[i]) begin
          m_k[i]++;
          if (m_k[i] == 1 + int'(m_len[i]) * pre_of(i) + H) begin
            m_act[i]  = 0;
            m_done[i] = 1;
            m_did[i]  = m_id[i];
            m_res[i]  = m_start[i] + m_len[i];
          end
        end else if (!was_done && rq != 2'b00) begin
          w = (rq == 2'b11) ? m_ptr[i] : rq[1];
          m_act[i]   = 1;
          m_k[i]     = 0;
          m_id[i]    = w;
          m_ptr[i]   = !w;
          m_start[i] = w ? st1[i] : st0[i];
          m_len[i]   = w ? ln1[i] : ln0[i];
        end
      end
    end
  end

  int n_en [2];
  int n_set[2];
  int n_oe [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int k, run_end;
      k       = m_k[i];
      run_end = int'(m_len[i]) * pre_of(i);
      chk($sformatf("gnt%0d", i), o_gnt[i], m_act[i] ? (m_id[i] ? 2 : 1) : 0);
      chk($sformatf("busy%0d", i), o_busy[i], m_act[i]);
      chk($sformatf("cnt_set%0d", i), o_set[i], m_act[i] && k == 0);
      chk($sformatf("cnt_set_val%0d", i), o_setv[i], m_start[i]);
      chk($sformatf("cnt_en%0d", i), o_en[i],
          m_act[i] && k >= 1 && k <= run_end && (k % pre_of(i)) == 0);
      chk($sformatf("cnt_oe%0d", i), o_oe[i], m_act[i] && k > run_end);
      chk($sformatf("result%0d", i), o_res[i], m_res[i]);
      chk($sformatf("done%0d", i), o_done[i], m_done[i]);
      chk($sformatf("done_id%0d", i), o_did[i], m_did[i]);
      if (o_en[i])  n_en[i]++;
      if (o_set[i]) n_set[i]++;
      if (o_oe[i])  n_oe[i]++;
    end
  end

  task automatic wait_for(input int inst, input bit want_done, output int at);
    bit hit;
    hit = 0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(negedge clk); #1;
      if (want_done ? o_done[inst] : (o_gnt[inst] != 2'b00)) hit = 1;
    end
    at = cyc;
    if (!hit) begin
      n_chk++; n_fail++;
      $display("FAIL timeout inst%0d waiting for %s", inst, want_done ? "done" : "gnt");
    end
  endtask

  task automatic run_single(input int inst, input logic [1:0] rq, input logic [7:0] st,
                            input logic [7:0] ln, input logic [7:0] exp_res,
                            input int exp_lat, input int exp_en);
    int g, d;
    n_en[inst] = 0; n_set[inst] = 0; n_oe[inst] = 0;
    if (rq == 2'b01) begin st0[inst] = st; ln0[inst] = ln; end
    else             begin st1[inst] = st; ln1[inst] = ln; end
    req[inst] = rq;
    wait_for(inst, 1'b0, g);
    chk("lit_gnt", o_gnt[inst], rq);
    st0[inst] = 8'h77; ln0[inst] = 8'h33; st1[inst] = 8'h99; ln1[inst] = 8'h44;
    wait_for(inst, 1'b1, d);
    req[inst] = 2'b00;
    chk("lit_result", o_res[inst], exp_res);
    chk("lit_done_id", o_did[inst], (rq == 2'b10) ? 1 : 0);
    chk("lit_latency", d - g, exp_lat);
    chk("lit_en_pulses", n_en[inst], exp_en);
    chk("lit_set_pulses", n_set[inst], 1);
    chk("lit_oe_cycles", n_oe[inst], H);
    @(negedge clk); #1;
  endtask

  initial begin
    int g, d;
    for (int i = 0; i < 2; i++) begin
      req[i] = 2'b00; st0[i] = 8'h00; ln0[i] = 8'h00; st1[i] = 8'h00; ln1[i] = 8'h00;
      n_en[i] = 0; n_set[i] = 0; n_oe[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("lit_reset_busy0", o_busy[0], 0);
    chk("lit_reset_result1", o_res[1], 0);

    run_single(0, 2'b01, 8'h10, 8'd5, 8'h15, 8, 5);
    run_single(0, 2'b01, 8'hA5, 8'd0, 8'hA5, 1 + H, 0);
    run_single(1, 2'b10, 8'hFE, 8'd4, 8'h02, 1 + 12 + H, 4);
    run_single(1, 2'b01, 8'h3C, 8'd0, 8'h3C, 1 + H, 0);

    // Reset asserted mid-RUN: everything clears without waiting for a clock edge.
    st1[1] = 8'h00; ln1[1] = 8'd50; req[1] = 2'b10;
    wait_for(1, 1'b0, g);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("lit_async_reset%0d", i),
          {o_gnt[i], o_busy[i], o_set[i], o_setv[i], o_en[i], o_oe[i], o_res[i], o_done[i], o_did[i]}, 0);
    req[1] = 2'b00;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk); #1;
      chk("lit_no_spurious_done", {o_done[0], o_done[1], o_busy[0], o_busy[1]}, 0);
    end

    // Round-robin with both requesting; each drops its bit on its own done.
    st0[0] = 8'h20; ln0[0] = 8'd2; st1[0] = 8'h30; ln1[0] = 8'd1; req[0] = 2'b11;
    wait_for(0, 1'b0, g);
    chk("lit_rr_first", o_gnt[0], 2'b01);
    wait_for(0, 1'b1, d);
    req[0] = 2'b10;
    chk("lit_rr_res0", o_res[0], 8'h22);
    wait_for(0, 1'b0, g);
    chk("lit_rr_second", o_gnt[0], 2'b10);
    chk("lit_rr_gap", g - d, 2);
    wait_for(0, 1'b1, d);
    req[0] = 2'b00;
    chk("lit_rr_res1", o_res[0], 8'h31);
    chk("lit_rr_id1", o_did[0], 1);
    repeat (2) @(negedge clk);
    #1 req[0] = 2'b11;
    wait_for(0, 1'b0, g);
    chk("lit_rr_again0", o_gnt[0], 2'b01);
    wait_for(0, 1'b1, d);
    req[0] = 2'b10;
    wait_for(0, 1'b0, g);
    chk("lit_rr_again1", o_gnt[0], 2'b10);
    wait_for(0, 1'b1, d);
    req[0] = 2'b00;
    repeat (2) @(negedge clk);

    // Requester 0 drops mid-run; its run still completes, then requester 1 is served.
    #1 st0[0] = 8'h40; ln0[0] = 8'd6; st1[0] = 8'hF0; ln1[0] = 8'd3; req[0] = 2'b11;
    wait_for(0, 1'b0, g);
    chk("lit_drop_gnt", o_gnt[0], 2'b01);
    repeat (3) @(negedge clk);
    #1 req[0] = 2'b10;
    wait_for(0, 1'b1, d);
    chk("lit_drop_id", o_did[0], 0);
    chk("lit_drop_res", o_res[0], 8'h46);
    wait_for(0, 1'b0, g);
    chk("lit_drop_next", o_gnt[0], 2'b10);
    chk("lit_drop_gap", g - d, 2);
    wait_for(0, 1'b1, d);
    req[0] = 2'b00;
    chk("lit_drop_res1", o_res[0], 8'hF3);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cnt_run_sched.md
Name: cnt_run_sched

Overview:
- Two-requester scheduler that shares one loadable 8-bit up-counter: load/increment/output-enable.
- Each requester asks for a "run": load a start value, increment a given number of times, then present the value.
- Arbitrates round-robin, sequences the counter's set/enable/output-enable controls, captures the final value, and reports completion per requester.
- Sits between requester logic and the counter instance in the top level.

Parameters:
- PRESCALE, 1, cycles per counter increment during RUN (legal 1..16).
- HOLD, 2, cycles cnt_oe is held high in SHOW (legal 1..16).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  2  level request per requester; held until done for that requester
- start0  input  8  start value, requester 0 (sampled at grant)
- len0  input  8  increment count, requester 0 (sampled at grant)
- start1  input  8  start value, requester 1
- len1  input  8  increment count, requester 1
- cnt_q  input  8  current counter value fed back from the counter
- gnt  output  2  one-hot grant, held LOAD through SHOW
- busy  output  1  high whenever state != IDLE
- cnt_set  output  1  counter load strobe
- cnt_set_val  output  8  value to load; latched start
- cnt_en  output  1  counter increment strobe
- cnt_oe  output  1  counter output-enable
- result  output  8  final counter value of last completed run
- done  output  1  one-cycle completion pulse
- done_id  output  1  requester index of the completed run, valid with done

Behaviour:
- Reset (async, any state): state=IDLE. gnt=0, busy=0, cnt_set=0, cnt_set_val=0, cnt_en=0, cnt_oe=0, result=0, done=0, done_id=0. Round-robin pointer favours requester 0.
- Counter contract: counter loads on the edge after cnt_set=1. It increments on each edge with cnt_en=1. The set strobe has priority in the counter.
- States:
  - IDLE -> LOAD.
  - LOAD -> RUN, or -> SHOW if latched len=0.
  - RUN -> SHOW.
  - SHOW -> IDLE.
- IDLE:
  - If done=0 and any req bit is high, grant on the next edge.
  - Only one bit high: grant that requester.
  - Both high: grant the requester not served last. After reset, requester 0.
  - On grant: latch start/len of the winner, set gnt one-hot, update the pointer, move to LOAD.
  - No grant while done=1; this gives a 1-cycle gap so the served requester can drop req.
- LOAD (exactly 1 cycle): cnt_set=1, cnt_set_val=latched start.
- RUN:
  - Prescale counter counts 0..PRESCALE-1.
  - cnt_en=1 in the cycle the prescale count equals PRESCALE-1. With PRESCALE=1 this means every cycle.
  - A remaining-count register is initialised to len and decremented on each cnt_en cycle.
  - After the cnt_en cycle that takes remaining to 0, move to SHOW.
  - RUN therefore lasts len*PRESCALE cycles.
- SHOW:
  - cnt_oe=1 for exactly HOLD cycles.
  - On the last SHOW edge: result<=cnt_q, done<=1, done_id<=granted index, gnt<=0, state<=IDLE.
- done is high for exactly one cycle (the first IDLE cycle). result holds until the next completion.
- Latency, grant edge to done high: 1+len*PRESCALE+HOLD cycles.
- Expected result = (start+len) mod 256. Wrap-around is the counter's natural 8-bit wrap; the controller does no range checks.
- len=0: LOAD->SHOW directly, no cnt_en pulses, result=start.
- Mid-run req drop: ignored; the run completes and done is still issued.
- Input stability: start/len changes after grant have no effect. A new request while busy waits in IDLE arbitration.
- Mutual exclusion: cnt_set, cnt_en and cnt_oe are never high in the same cycle. gnt is never 2'b11.
- Reset mid-run: all outputs return to reset values immediately. The counter's contents are not the controller's concern.

Test Plan:
- Reset defaults: assert rst_n=0 mid-RUN -> all outputs 0, busy=0 same cycle. Release -> IDLE, no spurious done.
- Single run, PRESCALE=1, HOLD=2: req=01, start0=8'h10, len0=5.
  - Expect gnt=01, one cnt_set cycle with cnt_set_val=8'h10, 5 consecutive cnt_en cycles, 2 cnt_oe cycles.
  - Expect done one cycle with done_id=0, result=8'h15, 8 cycles after grant.
- Wrap + prescale, PRESCALE=3: start1=8'hFE, len1=4 -> cnt_en every 3rd cycle (4 pulses), result=8'h02, done_id=1.
- len=0: start0=8'hA5, len0=0 -> no cnt_en, result=8'hA5, done 1+HOLD cycles after grant.
- Round-robin: req=11 held continuously, each requester drops req on its done.
  - Expect grant order 0,1 with a 1-cycle idle gap after each done.
  - Then re-raise both -> grant 0, then 1.
- Mid-run drop: req0 deasserted during RUN -> run completes, done_id=0, correct result. Pending req1 granted after the done cycle.
